ula_control: RTL and testbench
==============================

Name: ula_control

Overview:
- ALU ("ULA") control decoder for the RV32I datapath.
- Takes a 17-bit packed instruction field bundle and the 2-bit main-control `ula_op` class.
- Produces the 4-bit `ula_select` code driving the ULA.
- Sits between the main control unit and the ULA; output is registered (one pipeline stage).

Parameters:
- None. All encodings are fixed constants in the shared package.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- inst  input  17  packed fields {opcode[16:10], funct3[9:7], funct7[6:0]}.
- ula_op  input  2  operation class from main control.
- in_valid  input  1  inputs valid this cycle.
- ula_select  output  4  registered ULA operation code.
- out_valid  output  1  registered copy of in_valid.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values: ula_select=4'b0000 (ADD); out_valid=0.
- Latency: exactly 1 cycle. Inputs sampled at rising edge N appear on the outputs after edge N.
- out_valid follows in_valid every cycle.
- When in_valid=0, ula_select holds its previous value.
- Reset asserted mid-stream clears both outputs immediately; the first valid input after deassertion behaves normally.
- Select encoding: ADD=0000, SUB=0001, SLL=0010, SLT=0011, SLTU=0100, XOR=0101, SRL=0110, SRA=0111, OR=1000, AND=1001. Codes 1010–1111 are never produced.
- Decode by ula_op:
  - 00 (load/store address): ADD; inst ignored.
  - 01 (branch compare): SUB; inst ignored.
  - 10 (R-type): decode funct3/funct7.
    - funct3 000: funct7=0000000 → ADD; funct7=0100000 → SUB.
    - 001 → SLL; 010 → SLT; 011 → SLTU; 100 → XOR.
    - 101: funct7=0000000 → SRL; funct7=0100000 → SRA.
    - 110 → OR; 111 → AND.
  - 11 (I-type ALU): same table, except:
    - funct3 000 is always ADD (no SUBI).
    - Shifts use funct7[5] only to select SRL vs SRA.
- Illegal combinations decode to ADD:
  - R-type funct7 not in {0000000, 0100000}.
  - R-type funct7=0100000 with funct3 other than 000 or 101.
- The opcode field is not used for selection. It is used only by the optional illegal check.

Optional Feature:
- Macro: ULA_CTRL_ILLEGAL_EN.
- Defined:
  - Adds output port `illegal` (1 bit), registered with the same timing as ula_select; reset value 0.
  - `illegal` = 1 when any of the following holds for a valid input:
    - ula_op=10 and opcode≠0110011.
    - ula_op=11 and opcode≠0010011.
    - The funct7 combination is illegal as listed above.
  - `illegal` holds its value when in_valid=0.
- Undefined: the port does not exist; all other behaviour is identical.

Decomposition:
- Package ula_pkg holds:
  - the ULA select localparams (ULA_ADD … ULA_AND);
  - the ula_op class constants (OP_MEM=00, OP_BRANCH=01, OP_RTYPE=10, OP_ITYPE=11);
  - opcode constants 0110011 and 0010011;
  - field bit ranges for opcode, funct3 and funct7.
- One combinational sub-module, ula_funct_decode: maps (ula_op, funct3, funct7) to the next select value and the illegal flag.
- The top module holds only the registers.

Test Plan:
- Reset: assert rst with in_valid=1 and inst=0x0CC20 (SUB) → ula_select=0000 and out_valid=0 immediately, not waiting for a clock edge.
- Class override: inst={0110011,000,0000000}, ula_op=00 → 0000; same inst with ula_op=01 → 0001; each appears one cycle after sampling.
- R-type sweep with ula_op=10, 10 instructions (ADD, SUB, SLL, SLT, SLTU, SRL, SRA, XOR, OR, AND) applied back-to-back → 0000, 0001, 0010, 0011, 0100, 0110, 0111, 0101, 1000, 1001 on consecutive cycles.
- I-type, ula_op=11:
  - funct3=000, funct7=0100000 → 0000 (ADD, not SUB).
  - funct3=101, funct7=0100000 → 0111.
  - funct3=101, funct7=0000000 → 0110.
- Hold: load XOR, then drop in_valid and change inst to AND → ula_select stays 0101 and out_valid=0.
- Illegal (macro defined), ula_op=10:
  - funct7=0000001, funct3=000 → ula_select=0000 with illegal=1.
  - opcode=0010011 → illegal=1.
  - Then a legal ADD → illegal=0.

Source files
------------

// File: rtl/ula_pkg.sv
// rtl/ula_pkg.sv - shared encodings for the ULA control decoder
package ula_pkg;

    localparam int INST_W     = 17;
    localparam int OPCODE_MSB = 16;
    localparam int OPCODE_LSB = 10;
    localparam int FUNCT3_MSB = 9;
    localparam int FUNCT3_LSB = 7;
    localparam int FUNCT7_MSB = 6;
    localparam int FUNCT7_LSB = 0;

    localparam logic [3:0] ULA_ADD  = 4'b0000;
    localparam logic [3:0] ULA_SUB  = 4'b0001;
    localparam logic [3:0] ULA_SLL  = 4'b0010;
    localparam logic [3:0] ULA_SLT  = 4'b0011;
    localparam logic [3:0] ULA_SLTU = 4'b0100;
    localparam logic [3:0] ULA_XOR  = 4'b0101;
    localparam logic [3:0] ULA_SRL  = 4'b0110;
    localparam logic [3:0] ULA_SRA  = 4'b0111;
    localparam logic [3:0] ULA_OR   = 4'b1000;
    localparam logic [3:0] ULA_AND  = 4'b1001;

    localparam logic [1:0] OP_MEM    = 2'b00;
    localparam logic [1:0] OP_BRANCH = 2'b01;
    localparam logic [1:0] OP_RTYPE  = 2'b10;
    localparam logic [1:0] OP_ITYPE  = 2'b11;

    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE = 7'b0010011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // funct3 mapping with funct7 alternate forms resolved to the base op (ADD, SRL)
    function automatic logic [3:0] base_select(input logic [2:0] funct3);
        logic [3:0] sel;
        case (funct3)
            F3_ADD_SUB: sel = ULA_ADD;
            F3_SLL:     sel = ULA_SLL;
            F3_SLT:     sel = ULA_SLT;
            F3_SLTU:    sel = ULA_SLTU;
            F3_XOR:     sel = ULA_XOR;
            F3_SRL_SRA: sel = ULA_SRL;
            F3_OR:      sel = ULA_OR;
            F3_AND:     sel = ULA_AND;
            default:    sel = ULA_ADD;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/ula_funct_decode.sv
// rtl/ula_funct_decode.sv - maps (ula_op, funct3, funct7, opcode) to next ULA select and illegal flag
module ula_funct_decode
    import ula_pkg::*;
(
    input  logic [1:0] ula_op,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] select,
    output logic       illegal
);

    always_comb begin
        select  = ULA_ADD;
        illegal = 1'b0;
        case (ula_op)
            OP_MEM: begin
                select = ULA_ADD;
            end
            OP_BRANCH: begin
                select = ULA_SUB;
            end
            OP_RTYPE: begin
                illegal = (opcode != OPC_RTYPE);
                if (funct7 == F7_BASE) begin
                    select = base_select(funct3);
                end else if (funct7 == F7_ALT && funct3 == F3_ADD_SUB) begin
                    select = ULA_SUB;
                end else if (funct7 == F7_ALT && funct3 == F3_SRL_SRA) begin
                    select = ULA_SRA;
                end else begin
                    select  = ULA_ADD;
                    illegal = 1'b1;
                end
            end
            OP_ITYPE: begin
                // No SUBI: funct3 000 is ADD whatever funct7 holds; shifts look only at funct7[5]
                illegal = (opcode != OPC_ITYPE);
                select  = base_select(funct3);
                if (funct3 == F3_SRL_SRA && funct7[5]) begin
                    select = ULA_SRA;
                end
            end
            default: begin
                select  = ULA_ADD;
                illegal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ula_control.sv
// rtl/ula_control.sv - registered ULA control decoder; optional illegal output via ULA_CTRL_ILLEGAL_EN
module ula_control
    import ula_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [INST_W-1:0] inst,
    input  logic [1:0]        ula_op,
    input  logic              in_valid,
`ifdef ULA_CTRL_ILLEGAL_EN
    output logic              illegal,
`endif
    output logic [3:0]        ula_select,
    output logic              out_valid
);

    logic [3:0] dec_select;
    logic       dec_illegal;

    logic [3:0] ula_select_d, ula_select_q;
    logic       out_valid_d,  out_valid_q;

    ula_funct_decode u_decode (
        .ula_op  (ula_op),
        .opcode  (inst[OPCODE_MSB:OPCODE_LSB]),
        .funct3  (inst[FUNCT3_MSB:FUNCT3_LSB]),
        .funct7  (inst[FUNCT7_MSB:FUNCT7_LSB]),
        .select  (dec_select),
        .illegal (dec_illegal)
    );

    always_comb begin
        ula_select_d = in_valid ? dec_select : ula_select_q;
        out_valid_d  = in_valid;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ula_select_q <= ULA_ADD;
            out_valid_q  <= 1'b0;
        end else begin
            ula_select_q <= ula_select_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign ula_select = ula_select_q;
    assign out_valid  = out_valid_q;

`ifdef ULA_CTRL_ILLEGAL_EN
    logic illegal_d, illegal_q;

    always_comb begin
        illegal_d = in_valid ? dec_illegal : illegal_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign illegal = illegal_q;
`else
    logic unused_illegal;
    assign unused_illegal = dec_illegal;
`endif

endmodule

// File: tb/tb_ula_control.sv
// tb/tb_ula_control.sv - directed self-checking bench for ula_control
module tb_ula_control;

    logic        clk;
    logic        rst;
    logic [16:0] inst;
    logic [1:0]  ula_op;
    logic        in_valid;
    logic [3:0]  ula_select;
    logic        out_valid;
`ifdef ULA_CTRL_ILLEGAL_EN
    logic        illegal;
`endif

    int checks;
    int errors;

    ula_control dut (
        .clk        (clk),
        .rst        (rst),
        .inst       (inst),
        .ula_op     (ula_op),
        .in_valid   (in_valid),
`ifdef ULA_CTRL_ILLEGAL_EN
        .illegal    (illegal),
`endif
        .ula_select (ula_select),
        .out_valid  (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] mk(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7);
        return {opc, f3, f7};
    endfunction

    // drive at the falling edge, sample 1ns after the next rising edge
    task automatic step(input logic [16:0] i, input logic [1:0] op, input logic v);
        @(negedge clk);
        inst     = i;
        ula_op   = op;
        in_valid = v;
        @(posedge clk);
        #1;
    endtask

    localparam logic [6:0] R  = 7'b0110011;
    localparam logic [6:0] I  = 7'b0010011;
    localparam logic [6:0] B  = 7'b0000000;
    localparam logic [6:0] A  = 7'b0100000;

    logic [16:0] sweep_inst [10];
    logic [3:0]  sweep_exp  [10];

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        inst     = '0;
        ula_op   = 2'b00;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_select", {4'b0, ula_select}, 8'h00);
        check("reset_valid", {7'b0, out_valid}, 8'h00);
`ifdef ULA_CTRL_ILLEGAL_EN
        check("reset_illegal", {7'b0, illegal}, 8'h00);
`endif
        @(negedge clk);
        rst = 1'b0;

        // class override
        step(mk(R, 3'b000, B), 2'b00, 1'b1);
        check("mem_add", {4'b0, ula_select}, 8'h00);
        check("mem_valid", {7'b0, out_valid}, 8'h01);
        step(mk(R, 3'b000, B), 2'b01, 1'b1);
        check("branch_sub", {4'b0, ula_select}, 8'h01);

        // R-type sweep, back to back
        sweep_inst[0] = mk(R, 3'b000, B); sweep_exp[0] = 4'b0000;
        sweep_inst[1] = mk(R, 3'b000, A); sweep_exp[1] = 4'b0001;
        sweep_inst[2] = mk(R, 3'b001, B); sweep_exp[2] = 4'b0010;
        sweep_inst[3] = mk(R, 3'b010, B); sweep_exp[3] = 4'b0011;
        sweep_inst[4] = mk(R, 3'b011, B); sweep_exp[4] = 4'b0100;
        sweep_inst[5] = mk(R, 3'b101, B); sweep_exp[5] = 4'b0110;
        sweep_inst[6] = mk(R, 3'b101, A); sweep_exp[6] = 4'b0111;
        sweep_inst[7] = mk(R, 3'b100, B); sweep_exp[7] = 4'b0101;
        sweep_inst[8] = mk(R, 3'b110, B); sweep_exp[8] = 4'b1000;
        sweep_inst[9] = mk(R, 3'b111, B); sweep_exp[9] = 4'b1001;
        for (int k = 0; k < 10; k++) begin
            step(sweep_inst[k], 2'b10, 1'b1);
            check($sformatf("rtype_%0d", k), {4'b0, ula_select}, {4'b0, sweep_exp[k]});
`ifdef ULA_CTRL_ILLEGAL_EN
            check($sformatf("rtype_legal_%0d", k), {7'b0, illegal}, 8'h00);
`endif
        end

        // I-type
        step(mk(I, 3'b000, A), 2'b11, 1'b1);
        check("itype_addi", {4'b0, ula_select}, 8'h00);
        step(mk(I, 3'b101, A), 2'b11, 1'b1);
        check("itype_srai", {4'b0, ula_select}, 8'h07);
        step(mk(I, 3'b101, B), 2'b11, 1'b1);
        check("itype_srli", {4'b0, ula_select}, 8'h06);
        step(mk(I, 3'b101, 7'b1111111), 2'b11, 1'b1);
        check("itype_srai_f7bit5", {4'b0, ula_select}, 8'h07);

        // illegal funct7 combinations fall back to ADD
        step(mk(R, 3'b001, A), 2'b10, 1'b1);
        check("rtype_alt_sll", {4'b0, ula_select}, 8'h00);
        step(mk(R, 3'b111, B), 2'b10, 1'b1);
        step(mk(R, 3'b101, 7'b0000001), 2'b10, 1'b1);
        check("rtype_bad_f7_shift", {4'b0, ula_select}, 8'h00);

        // hold while invalid
        step(mk(R, 3'b100, B), 2'b10, 1'b1);
        check("hold_load_xor", {4'b0, ula_select}, 8'h05);
        step(mk(R, 3'b111, B), 2'b10, 1'b0);
        check("hold_select", {4'b0, ula_select}, 8'h05);
        check("hold_valid", {7'b0, out_valid}, 8'h00);
        step(mk(R, 3'b111, B), 2'b10, 1'b1);
        check("resume_and", {4'b0, ula_select}, 8'h09);
        check("resume_valid", {7'b0, out_valid}, 8'h01);

`ifdef ULA_CTRL_ILLEGAL_EN
        step(mk(R, 3'b000, 7'b0000001), 2'b10, 1'b1);
        check("illegal_f7_select", {4'b0, ula_select}, 8'h00);
        check("illegal_f7_flag", {7'b0, illegal}, 8'h01);
        step(mk(R, 3'b000, B), 2'b10, 1'b0);
        check("illegal_hold", {7'b0, illegal}, 8'h01);
        step(mk(I, 3'b000, B), 2'b10, 1'b1);
        check("illegal_opcode_r", {7'b0, illegal}, 8'h01);
        step(mk(R, 3'b000, B), 2'b11, 1'b1);
        check("illegal_opcode_i", {7'b0, illegal}, 8'h01);
        step(mk(R, 3'b000, B), 2'b10, 1'b1);
        check("legal_add_clears", {7'b0, illegal}, 8'h00);
        step(mk(R, 3'b000, 7'b0000001), 2'b10, 1'b1);
        check("illegal_before_rst", {7'b0, illegal}, 8'h01);
`endif

        // asynchronous reset mid-stream
        step(17'h0CC20, 2'b10, 1'b1);
        check("pre_reset_sub", {4'b0, ula_select}, 8'h01);
        @(negedge clk);
        inst     = 17'h0CC20;
        ula_op   = 2'b10;
        in_valid = 1'b1;
        rst      = 1'b1;
        #1;
        check("async_reset_select", {4'b0, ula_select}, 8'h00);
        check("async_reset_valid", {7'b0, out_valid}, 8'h00);
`ifdef ULA_CTRL_ILLEGAL_EN
        check("async_reset_illegal", {7'b0, illegal}, 8'h00);
`endif
        @(posedge clk);
        #1;
        check("reset_held_select", {4'b0, ula_select}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        step(17'h0CC20, 2'b10, 1'b1);
        check("post_reset_sub", {4'b0, ula_select}, 8'h01);
        check("post_reset_valid", {7'b0, out_valid}, 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
